mips_multicycle_control: RTL

- Multi-cycle MIPS control FSM; replaces the single-cycle decoder once the datapath shares one memory and one ALU across cycles.
- Sequences fetch, decode, execute, memory and writeback; drives every datapath mux/enable from current state, latched opcode and a memory-ready handshake.
- Sits beside the datapath; opcode comes from the instruction register, which is stable from DECODE to the end of the instruction.

---
 rtl/mips_multicycle_control.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// -----------------------------------------------------------------------------
// Multi-cycle MIPS control FSM. One shared memory and one shared ALU are
// sequenced through fetch, decode, execute, memory and writeback. Every
// datapath mux and enable is driven from the current state, the opcode held
// in the instruction register, and a memory-ready handshake.
//
// Parameters
//   MEM_TIMEOUT : max cycles spent waiting for memReady in one memory state
//                 before the instruction is aborted (0 disables the timeout)
//   TMR_W       : wait-counter width, 2**TMR_W must exceed MEM_TIMEOUT
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   opcode[5:0]         : instr[31:26] from the IR (stable DECODE..end)
//   memReady            : memory completes the current read/write this cycle
//   pcWrite/pcWriteCond : unconditional / branch-conditional PC load
//   iorD                : memory address select (0=PC, 1=ALUOut)
//   memRead/memWrite    : memory requests
//   irWrite             : load the instruction register
//   regDst[1:0]         : 00=rt, 01=rd, 10=r31
//   memToReg[1:0]       : 00=ALUOut, 01=MDR, 10=PC
//   aluSrcA             : 0=PC, 1=A
//   aluSrcB[1:0]        : 00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   aluOp[1:0]          : 00=add, 01=sub, 10=funct
//   pcSource[1:0]       : 00=ALU, 01=ALUOut, 10=jump target
//   regWrite            : register file write
//   instrDone           : pulse on the last cycle of each instruction
//   illegalOp           : pulse, unsupported opcode seen in DECODE
//   memTimeout          : pulse, memory wait aborted
//   state[3:0]          : current state, for debug
// -----------------------------------------------------------------------------
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       regWrite,
  output logic       instrDone,
  output logic       illegalOp,
  output logic       memTimeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Counter value seen in the last permitted wait cycle.
  localparam logic [TMR_W-1:0] TMO_LAST =
    (MEM_TIMEOUT == 0) ? '0 : TMR_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] wait_q, wait_d;

  logic mem_state;
  logic timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Only the three states that wait on memory use the counter.
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                     (state_q == S_MEMWR);

  // memReady takes priority: a timeout only fires while still not ready.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !memReady &&
                       (wait_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 2'b00;
    memToReg    = 2'b00;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    regWrite    = 1'b0;
    instrDone   = 1'b0;
    illegalOp   = 1'b0;
    memTimeout  = 1'b0;

    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;               // PC + 4 computed while fetching
        irWrite = memReady;
        pcWrite = memReady;
        if (memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;               // branch target precomputed into ALUOut
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_JAL:        state_d = S_JAL;
          OP_ADDI:       state_d = S_ADDIEX;
          default: begin
            illegalOp = 1'b1;
            instrDone = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite  = 1'b1;
        memToReg  = 2'b01;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (memReady) begin
          instrDone = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        regDst    = 2'b01;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        instrDone   = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pcWrite   = 1'b1;
        pcSource  = 2'b10;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC and r31 written together; the register file sees the old PC+4.
        pcWrite   = 1'b1;
        pcSource  = 2'b10;
        regWrite  = 1'b1;
        regDst    = 2'b10;
        memToReg  = 2'b10;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;    // unused encodings recover silently
    endcase

    if (timeout_hit) begin
      memTimeout = 1'b1;
      state_d    = S_FETCH;
    end

    // Reset blanks every output immediately, including state-derived ones.
    if (rst) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      regDst      = 2'b00;
      memToReg    = 2'b00;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      pcSource    = 2'b00;
      regWrite    = 1'b0;
      instrDone   = 1'b0;
      illegalOp   = 1'b0;
      memTimeout  = 1'b0;
    end
  end

  // Counter restarts on every state entry (a timeout counts as re-entering
  // FETCH), on every ready cycle, and outside the memory states.
  always_comb begin
    if (memReady || timeout_hit || !mem_state || (state_d != state_q)) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + TMR_W'(1);
    end
  end

  assign state = rst ? 4'd0 : state_q;

endmodule
